// File: rtl/rgb_hue_sequencer_pkg.sv
// Shared types and defaults for the mp2 RGB hue sequencer.
// Phase encoding is also the value driven on the phase output.
package mp2_pkg;

  localparam int CLK_HZ_DEF      = 12_000_000;
  localparam int PWM_BITS_DEF    = 8;
  localparam int STEP_CYCLES_DEF = 7812;

  typedef enum logic [2:0] {
    P0 = 3'd0,
    P1 = 3'd1,
    P2 = 3'd2,
    P3 = 3'd3,
    P4 = 3'd4,
    P5 = 3'd5
  } hue_phase_t;

endpackage

// File: rtl/rgb_hue_sequencer_pwm_channel.sv
// One PWM channel: shadow duty register reloaded at the counter wrap,
// followed by a registered active-low compare so the pin never glitches.
module pwm_channel #(
  parameter int                  PWM_BITS = 8,
  parameter logic [PWM_BITS-1:0] DUTY_RST = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic [PWM_BITS-1:0] duty_in,
  input  logic                load,
  output logic                led_n
);

  logic [PWM_BITS-1:0] r_shadow;
  logic                r_led_n;

  // The compare uses the pre-load shadow; on the load cycle pwm_cnt is MAX,
  // so the outgoing duty can never turn the LED on there anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= DUTY_RST;
      r_led_n  <= 1'b1;
    end else begin
      if (load) begin
        r_shadow <= duty_in;
      end
      r_led_n <= ~(pwm_cnt < r_shadow);
    end
  end

  assign led_n = r_led_n;

endmodule

// File: rtl/rgb_hue_sequencer.sv
// Six-phase RGB colour wheel: prescaler, level counter, hue FSM and
// free-running PWM counter feeding three glitch-free active-low channels.
//
// state | meaning
// P0    | R hold,  G rising
// P1    | G hold,  R falling
// P2    | G hold,  B rising
// P3    | B hold,  G falling
// P4    | B hold,  R rising
// P5    | R hold,  B falling (wrap to P0 pulses wheel_done)
module rgb_hue_sequencer
  import mp2_pkg::*;
#(
  parameter int CLK_HZ      = CLK_HZ_DEF,
  parameter int PWM_BITS    = PWM_BITS_DEF,
  parameter int STEP_CYCLES = STEP_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       RGB_R,
  output logic       RGB_G,
  output logic       RGB_B,
  output logic [2:0] phase,
  output logic       wheel_done
);

  localparam logic [PWM_BITS-1:0] MAX      = {PWM_BITS{1'b1}};
  localparam int                  PRE_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(STEP_CYCLES - 1);

  if (CLK_HZ <= 0) begin : g_bad_clk_hz
    $error("rgb_hue_sequencer: CLK_HZ must be positive");
  end

  logic [PRE_W-1:0]    r_pre;
  logic [PWM_BITS-1:0] r_level;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  hue_phase_t          r_phase;
  logic                r_wheel_done;

  hue_phase_t          w_phase_nxt;
  logic                w_wheel_done_nxt;
  logic                w_tick;
  logic                w_level_wrap;
  logic                w_load;
  logic [PWM_BITS-1:0] w_rise;
  logic [PWM_BITS-1:0] w_fall;
  logic [PWM_BITS-1:0] w_duty_r;
  logic [PWM_BITS-1:0] w_duty_g;
  logic [PWM_BITS-1:0] w_duty_b;

  assign w_tick       = en && (r_pre == PRE_LAST);
  assign w_level_wrap = w_tick && (r_level == MAX);
  assign w_load       = (r_pwm_cnt == MAX);
  assign w_rise       = r_level;
  assign w_fall       = MAX - r_level;

  // pwm_cnt is never gated so the LEDs keep their colour while en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre     <= '0;
      r_level   <= '0;
      r_pwm_cnt <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      if (en) begin
        r_pre <= w_tick ? '0 : r_pre + 1'b1;
      end
      if (w_tick) begin
        r_level <= r_level + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase      <= P0;
      r_wheel_done <= 1'b0;
    end else begin
      r_phase      <= w_phase_nxt;
      r_wheel_done <= w_wheel_done_nxt;
    end
  end

  always_comb begin
    w_phase_nxt      = r_phase;
    w_wheel_done_nxt = 1'b0;
    w_duty_r         = '0;
    w_duty_g         = '0;
    w_duty_b         = '0;
    case (r_phase)
      P0: begin
        w_duty_r = MAX;
        w_duty_g = w_rise;
        if (w_level_wrap) w_phase_nxt = P1;
      end
      P1: begin
        w_duty_r = w_fall;
        w_duty_g = MAX;
        if (w_level_wrap) w_phase_nxt = P2;
      end
      P2: begin
        w_duty_g = MAX;
        w_duty_b = w_rise;
        if (w_level_wrap) w_phase_nxt = P3;
      end
      P3: begin
        w_duty_g = w_fall;
        w_duty_b = MAX;
        if (w_level_wrap) w_phase_nxt = P4;
      end
      P4: begin
        w_duty_r = w_rise;
        w_duty_b = MAX;
        if (w_level_wrap) w_phase_nxt = P5;
      end
      P5: begin
        w_duty_r = MAX;
        w_duty_b = w_fall;
        if (w_level_wrap) begin
          w_phase_nxt      = P0;
          w_wheel_done_nxt = 1'b1;
        end
      end
      default: w_phase_nxt = P0;
    endcase
  end

  pwm_channel #(.PWM_BITS(PWM_BITS), .DUTY_RST(MAX)) u_pwm_r (
    .clk     (clk),
    .rst_n   (rst_n),
    .pwm_cnt (r_pwm_cnt),
    .duty_in (w_duty_r),
    .load    (w_load),
    .led_n   (RGB_R)
  );

  pwm_channel #(.PWM_BITS(PWM_BITS), .DUTY_RST('0)) u_pwm_g (
    .clk     (clk),
    .rst_n   (rst_n),
    .pwm_cnt (r_pwm_cnt),
    .duty_in (w_duty_g),
    .load    (w_load),
    .led_n   (RGB_G)
  );

  pwm_channel #(.PWM_BITS(PWM_BITS), .DUTY_RST('0)) u_pwm_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .pwm_cnt (r_pwm_cnt),
    .duty_in (w_duty_b),
    .load    (w_load),
    .led_n   (RGB_B)
  );

  assign phase      = r_phase;
  assign wheel_done = r_wheel_done;

endmodule

// File: tb/tb_rgb_hue_sequencer.sv
// Scoreboard bench for rgb_hue_sequencer with PWM_BITS=3, STEP_CYCLES=4:
// stimulus pushes expectations, a monitor pops and compares on each negedge.
module tb_rgb_hue_sequencer;

  localparam int PWM_BITS    = 3;
  localparam int STEP_CYCLES = 4;
  localparam int MAX         = 7;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b0;
  logic       RGB_R;
  logic       RGB_G;
  logic       RGB_B;
  logic [2:0] phase;
  logic       wheel_done;

  always #5 clk = ~clk;

  rgb_hue_sequencer #(
    .CLK_HZ      (12_000_000),
    .PWM_BITS    (PWM_BITS),
    .STEP_CYCLES (STEP_CYCLES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .RGB_R      (RGB_R),
    .RGB_G      (RGB_G),
    .RGB_B      (RGB_B),
    .phase      (phase),
    .wheel_done (wheel_done)
  );

  typedef enum {K_CYC, K_CLR, K_CNT} kind_e;
  typedef struct {
    kind_e      kind;
    logic [2:0] rgb;
    logic [2:0] ph;
    logic       wd;
    int         c_r;
    int         c_g;
    int         c_b;
    int         c_wd;
    string      tag;
    int         idx;
  } item_t;

  item_t q[$];
  event  ev_samp;
  int    n_checks = 0;
  int    n_errors = 0;

  // Reference model state: tick count since reset determines level and phase.
  int         m_pre;
  int         m_tc;
  int         m_pwm;
  int         m_k;
  int         m_sh[3];
  logic [2:0] m_led;
  logic       m_wd;

  function automatic int duty(input int ch, input int tc);
    int lv;
    int ph;
    int d[3];
    lv = tc % 8;
    ph = (tc / 8) % 6;
    case (ph)
      0:       d = '{MAX, lv, 0};
      1:       d = '{MAX - lv, MAX, 0};
      2:       d = '{0, MAX, lv};
      3:       d = '{0, MAX - lv, MAX};
      4:       d = '{lv, 0, MAX};
      default: d = '{MAX, 0, MAX - lv};
    endcase
    return d[ch];
  endfunction

  task automatic model_reset();
    m_pre = 0;
    m_tc  = 0;
    m_pwm = 0;
    m_k   = 0;
    m_sh  = '{MAX, 0, 0};
    m_led = 3'b111;
    m_wd  = 1'b0;
  endtask

  task automatic push_cyc(input logic [2:0] rgb, input logic [2:0] ph, input logic wd,
                          input string tag, input int idx);
    item_t it;
    it.kind = K_CYC; it.rgb = rgb; it.ph = ph; it.wd = wd;
    it.c_r = -1; it.c_g = -1; it.c_b = -1; it.c_wd = -1;
    it.tag = tag; it.idx = idx;
    q.push_back(it);
  endtask

  task automatic push_clr();
    item_t it;
    it.kind = K_CLR; it.rgb = '0; it.ph = '0; it.wd = 1'b0;
    it.c_r = -1; it.c_g = -1; it.c_b = -1; it.c_wd = -1;
    it.tag = "clr"; it.idx = 0;
    q.push_back(it);
  endtask

  task automatic push_cnt(input string tag, input int cr, input int cg, input int cb, input int cw);
    item_t it;
    it.kind = K_CNT; it.rgb = '0; it.ph = '0; it.wd = 1'b0;
    it.c_r = cr; it.c_g = cg; it.c_b = cb; it.c_wd = cw;
    it.tag = tag; it.idx = 0;
    q.push_back(it);
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input logic e, input int n, input string tag);
    logic tick;
    for (int s = 0; s < n; s++) begin
      en = e;
      @(posedge clk);
      tick = e && (m_pre == STEP_CYCLES - 1);
      m_wd = tick && (m_tc % 8 == 7) && ((m_tc / 8) % 6 == 5);
      for (int ch = 0; ch < 3; ch++) m_led[2-ch] = !(m_pwm < m_sh[ch]);
      if (m_pwm == MAX) begin
        for (int ch = 0; ch < 3; ch++) m_sh[ch] = duty(ch, m_tc);
      end
      if (e) m_pre = tick ? 0 : m_pre + 1;
      if (tick) m_tc++;
      m_pwm = (m_pwm + 1) % (MAX + 1);
      push_cyc(m_led, 3'((m_tc / 8) % 6), m_wd, tag, m_k);
      m_k++;
      @(negedge clk);
    end
  endtask

  initial begin : monitor
    item_t it;
    int cr;
    int cg;
    int cb;
    int cw;
    cr = 0; cg = 0; cb = 0; cw = 0;
    forever begin
      @(negedge clk or ev_samp);
      while (q.size() > 0) begin
        it = q.pop_front();
        case (it.kind)
          K_CYC: begin
            n_checks++;
            if ({RGB_R, RGB_G, RGB_B, phase, wheel_done} !== {it.rgb, it.ph, it.wd}) begin
              n_errors++;
              $display("FAIL %s k=%0d: got rgb=%b phase=%0d wd=%b, expected rgb=%b phase=%0d wd=%b",
                       it.tag, it.idx, {RGB_R, RGB_G, RGB_B}, phase, wheel_done,
                       it.rgb, it.ph, it.wd);
            end
            if (!RGB_R) cr++;
            if (!RGB_G) cg++;
            if (!RGB_B) cb++;
            if (wheel_done) cw++;
          end
          K_CLR: begin
            cr = 0; cg = 0; cb = 0; cw = 0;
          end
          default: begin
            if (it.c_r >= 0) begin
              n_checks++;
              if (cr != it.c_r) begin
                n_errors++;
                $display("FAIL %s: R low cycles got %0d, expected %0d", it.tag, cr, it.c_r);
              end
            end
            if (it.c_g >= 0) begin
              n_checks++;
              if (cg != it.c_g) begin
                n_errors++;
                $display("FAIL %s: G low cycles got %0d, expected %0d", it.tag, cg, it.c_g);
              end
            end
            if (it.c_b >= 0) begin
              n_checks++;
              if (cb != it.c_b) begin
                n_errors++;
                $display("FAIL %s: B low cycles got %0d, expected %0d", it.tag, cb, it.c_b);
              end
            end
            if (it.c_wd >= 0) begin
              n_checks++;
              if (cw != it.c_wd) begin
                n_errors++;
                $display("FAIL %s: wheel_done pulses got %0d, expected %0d", it.tag, cw, it.c_wd);
              end
            end
            cr = 0; cg = 0; cb = 0; cw = 0;
          end
        endcase
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    model_reset();
    repeat (3) @(negedge clk);
    #2;
    push_cyc(3'b111, 3'd0, 1'b0, "reset_hold", 0);
    -> ev_samp;
    @(negedge clk);
    rst_n = 1'b1;
    push_clr();

    step(1'b0, 1, "first_edge");
    step(1'b0, 63, "hold");
    push_cnt("hold64", 56, 0, 0, 0);

    // Align ticks to pwm_cnt==MAX so a tick coincides with the shadow load.
    step(1'b0, 4, "align");
    step(1'b1, 12, "shadow_lead");
    push_clr();
    step(1'b0, 8, "shadow_old");
    push_cnt("shadow_old_period", 7, 2, 0, 0);
    step(1'b0, 8, "shadow_new");
    push_cnt("shadow_new_period", 7, 3, 0, 0);

    step(1'b1, 290, "wheel");
    push_cnt("wheel_done_once", -1, -1, -1, 1);

    #2 rst_n = 1'b0;
    #1;
    push_cyc(3'b111, 3'd0, 1'b0, "async_reset", 0);
    -> ev_samp;
    model_reset();
    #1 rst_n = 1'b1;
    push_clr();

    step(1'b1, 8, "restart");
    push_cnt("restart_period", 7, 0, 0, 0);
    step(1'b1, 32, "restart_step");

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
